// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM channel-1 arbiter: port indices, FSM states, latched command.
package sdram_arb_pkg;

  localparam int NUM_PORTS  = 3;
  localparam int PORT_DL    = 0;
  localparam int PORT_SS    = 1;
  localparam int PORT_CORE  = 2;

  localparam int CMD_ADDR_W = 27;
  localparam int CMD_DATA_W = 32;

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic                  rnw;
    logic [CMD_ADDR_W-1:0] addr;
    logic [3:0]            be;
    logic [CMD_DATA_W-1:0] din;
  } cmd_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Grant selection among pending ports. Fixed priority (port 0 highest) by default;
// round-robin after the last granted port when SDRAM_ARB_RR_EN is defined.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [1:0]           last,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 vld
);

`ifdef SDRAM_ARB_RR_EN
  int idx;
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last) + k) % NUM_PORTS;
      if (gnt == '0 && pending[idx]) gnt[idx] = 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;
  // isolate lowest set bit: download > savestate > core
  assign gnt = pending & (~pending + NUM_PORTS'(1));
`endif

  assign vld = |pending;

endmodule

// File: rtl/sdram_arbiter.sv
// Shares SDRAM channel 1 between download, savestate and core requesters using the
// pulse-req/pulse-done handshake, with a WAIT watchdog. Optional SDRAM_ARB_RR_EN: round-robin grant.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                   clk1x,
  input  logic                   reset_n,
  input  logic [2:0]             req_ena,
  input  logic [2:0]             req_rnw,
  input  logic [3*ADDR_W-1:0]    req_addr,
  input  logic [3*4-1:0]         req_be,
  input  logic [3*DATA_W-1:0]    req_din,
  output logic [2:0]             req_done,
  output logic [DATA_W-1:0]      req_dout,
  output logic                   mem_req,
  output logic                   mem_rnw,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [3:0]             mem_be,
  output logic [DATA_W-1:0]      mem_din,
  input  logic                   mem_ready,
  input  logic [DATA_W-1:0]      mem_dout,
  output logic                   err_overrun,
  output logic                   err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t                  state, state_nxt;
  logic [NUM_PORTS-1:0]    pending, pending_nxt, take, pick_gnt;
  cmd_t [NUM_PORTS-1:0]    lat;
  logic [1:0]              gnt_port, last, pick_idx;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    pick_vld, grant, fin, fin_ok, ovr_hit;

  sdram_arb_pick u_pick (
    .pending (pending),
    .last    (last),
    .gnt     (pick_gnt),
    .vld     (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (pick_gnt[i]) pick_idx = 2'(i);
  end

  always_comb begin
    state_nxt = state;
    take      = '0;
    grant     = 1'b0;
    fin       = 1'b0;
    fin_ok    = 1'b0;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          take      = pick_gnt;
          grant     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
        // a ready arriving on the expiry cycle still counts as success
        if (mem_ready) begin
          fin       = 1'b1;
          fin_ok    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a pulse on the port being granted this cycle re-arms it rather than overrunning
  assign pending_nxt = (pending & ~take) | req_ena;
  assign ovr_hit     = |(req_ena & pending & ~take);

  always_ff @(posedge clk1x) begin
    if (!reset_n) begin
      state       <= IDLE;
      pending     <= '0;
      lat         <= '0;
      gnt_port    <= '0;
      last        <= 2'(PORT_CORE);
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_rnw     <= 1'b1;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_din     <= '0;
      req_done    <= '0;
      req_dout    <= '0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      cnt      <= cnt_nxt;
      mem_req  <= grant;
      req_done <= '0;
      if (ovr_hit) err_overrun <= 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req_ena[i] && !(pending[i] && !take[i])) begin
          lat[i].rnw  <= req_rnw[i];
          lat[i].addr <= CMD_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
          lat[i].be   <= req_be[i*4 +: 4];
          lat[i].din  <= CMD_DATA_W'(req_din[i*DATA_W +: DATA_W]);
        end
      end
      if (grant) begin
        mem_rnw  <= lat[pick_idx].rnw;
        mem_addr <= ADDR_W'(lat[pick_idx].addr);
        mem_be   <= lat[pick_idx].be;
        mem_din  <= DATA_W'(lat[pick_idx].din);
        gnt_port <= pick_idx;
        last     <= pick_idx;
      end
      if (fin) begin
        req_done[gnt_port] <= 1'b1;
        req_dout           <= fin_ok ? mem_dout : '0;
        if (!fin_ok) err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: grant order, latency, overrun, watchdog, reset abort.
module tb_sdram_arbiter;
  localparam int AW = 27;
  localparam int DW = 32;

  logic          clk1x = 1'b0;
  logic          reset_n;
  logic [2:0]    req_ena, req_rnw, req_done;
  logic [3*AW-1:0] req_addr;
  logic [11:0]   req_be;
  logic [3*DW-1:0] req_din;
  logic [DW-1:0] req_dout, mem_din, mem_dout;
  logic          mem_req, mem_rnw, mem_ready, err_overrun, err_timeout;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;

  int n_chk = 0;
  int n_fail = 0;

  logic [AW-1:0] exp_addr [3];
  logic [DW-1:0] exp_din  [3];
  logic          exp_rnw  [3];
  logic [3:0]    exp_be   [3];

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(1023)) dut (
    .clk1x(clk1x), .reset_n(reset_n),
    .req_ena(req_ena), .req_rnw(req_rnw), .req_addr(req_addr), .req_be(req_be),
    .req_din(req_din), .req_done(req_done), .req_dout(req_dout),
    .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_din(mem_din), .mem_ready(mem_ready), .mem_dout(mem_dout),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk1x = ~clk1x;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk1x);
    #1;
  endtask

  task automatic set_port(input int p, input logic rnw, input logic [AW-1:0] a,
                          input logic [3:0] be, input logic [DW-1:0] d);
    req_rnw[p]          = rnw;
    req_addr[p*AW +: AW] = a;
    req_be[p*4 +: 4]    = be;
    req_din[p*DW +: DW] = d;
    exp_rnw[p] = rnw; exp_addr[p] = a; exp_be[p] = be; exp_din[p] = d;
  endtask

  // called in the cycle where mem_req for port p must be high
  task automatic chk_grant(input int p);
    check($sformatf("mreq_p%0d", p), 64'(mem_req), 64'd1);
    check($sformatf("maddr_p%0d", p), 64'(mem_addr), 64'(exp_addr[p]));
    check($sformatf("mdin_p%0d", p), 64'(mem_din), 64'(exp_din[p]));
    check($sformatf("mrnw_p%0d", p), 64'(mem_rnw), 64'(exp_rnw[p]));
    check($sformatf("mbe_p%0d", p), 64'(mem_be), 64'(exp_be[p]));
  endtask

  // wait lat cycles, return ready+data, check done; rereq pulses ena in the done cycle
  task automatic finish(input int p, input logic [DW-1:0] rd, input int lat, input logic [2:0] rereq);
    repeat (lat) tick;
    check("mreq_low_wait", 64'(mem_req), 64'd0);
    mem_ready = 1'b1; mem_dout = rd;
    tick;
    mem_ready = 1'b0; mem_dout = '0;
    req_ena = rereq;
    check($sformatf("done_p%0d", p), 64'(req_done), 64'(3'b001 << p));
    check($sformatf("dout_p%0d", p), 64'(req_dout), 64'(rd));
    check("mreq_low_done", 64'(mem_req), 64'd0);
    tick;
    req_ena = '0;
  endtask

  initial begin
    reset_n = 1'b0; req_ena = '0; req_rnw = '0; req_addr = '0; req_be = '0; req_din = '0;
    mem_ready = 1'b0; mem_dout = '0;
    tick; tick;
    check("rst_mreq", 64'(mem_req), 64'd0);
    check("rst_mrnw", 64'(mem_rnw), 64'd1);
    check("rst_maddr", 64'(mem_addr), 64'd0);
    check("rst_done", 64'(req_done), 64'd0);
    check("rst_dout", 64'(req_dout), 64'd0);
    check("rst_errs", 64'({err_overrun, err_timeout}), 64'd0);
    reset_n = 1'b1;
    tick;

    // single read on core port, ready 5 cycles after mem_req
    set_port(2, 1'b1, 27'h0100000, 4'hF, 32'h0);
    req_ena = 3'b100;
    tick;
    req_ena = '0;
    check("lat_t1_mreq", 64'(mem_req), 64'd0);
    tick;
    chk_grant(2);
    finish(2, 32'hDEADBEEF, 5, 3'b000);
    check("single_idle_mreq", 64'(mem_req), 64'd0);

    // all three ports at once, writes; each re-requests in its done cycle
    set_port(0, 1'b0, 27'h0000040, 4'h1, 32'h11110000);
    set_port(1, 1'b0, 27'h2000080, 4'h3, 32'h22220000);
    set_port(2, 1'b0, 27'h7FFFFFC, 4'hC, 32'h33330000);
    req_ena = 3'b111;
    tick;
    req_ena = '0;
    tick;
`ifdef SDRAM_ARB_RR_EN
    chk_grant(0); finish(0, 32'hA0, 2, 3'b001);
    chk_grant(1); finish(1, 32'hA1, 2, 3'b010);
    chk_grant(2); finish(2, 32'hA2, 2, 3'b100);
    chk_grant(0); finish(0, 32'hA3, 2, 3'b000);
    chk_grant(1); finish(1, 32'hA4, 2, 3'b000);
    chk_grant(2); finish(2, 32'hA5, 2, 3'b000);
`else
    chk_grant(0); finish(0, 32'hA0, 2, 3'b001);
    chk_grant(1); finish(1, 32'hA1, 2, 3'b000);
    chk_grant(0); finish(0, 32'hA2, 2, 3'b000);
    chk_grant(2); finish(2, 32'hA3, 2, 3'b000);
`endif
    check("no_overrun_yet", 64'(err_overrun), 64'd0);
    check("drained", 64'(mem_req), 64'd0);

    // overrun: port 2 pulses again while waiting behind port 0
    set_port(0, 1'b1, 27'h0000100, 4'hF, 32'h0);
    set_port(2, 1'b0, 27'h0123456, 4'h5, 32'hCAFEF00D);
    req_ena = 3'b101;
    tick;
    req_ena = '0;
    tick;
    chk_grant(0);
    req_addr[2*AW +: AW] = 27'h0654321;
    req_din[2*DW +: DW]  = 32'hBAD0BAD0;
    req_ena = 3'b100;
    tick;
    req_ena = '0;
    check("overrun_set", 64'(err_overrun), 64'd1);
    finish(0, 32'h5A5A5A5A, 1, 3'b000);
    chk_grant(2);
    finish(2, 32'h0000BEEF, 3, 3'b000);
    check("overrun_sticky", 64'(err_overrun), 64'd1);
    check("no_timeout_yet", 64'(err_timeout), 64'd0);

    // watchdog: port 1 never gets ready; port 2 queued behind it
    set_port(1, 1'b1, 27'h0ABCDE0, 4'hF, 32'h0);
    set_port(2, 1'b0, 27'h0000200, 4'hF, 32'h77777777);
    req_ena = 3'b010;
    tick;
    req_ena = 3'b100;
    tick;
    req_ena = '0;
    chk_grant(1);
    mem_dout = 32'h12345678;
    repeat (1022) tick;
    check("to_not_yet", 64'(req_done), 64'd0);
    tick;
    check("to_done", 64'(req_done), 64'b010);
    check("to_dout", 64'(req_dout), 64'd0);
    check("to_err", 64'(err_timeout), 64'd1);
    mem_dout = '0;
    tick;
    chk_grant(2);
    finish(2, 32'h0, 3, 3'b000);

    // ready on the expiry cycle wins over timeout
    req_ena = 3'b010;
    tick;
    req_ena = '0;
    tick;
    chk_grant(1);
    finish(1, 32'hFEEDFACE, 1022, 3'b000);

    // reset during WAIT, then a stale ready
    req_ena = 3'b001;
    tick;
    req_ena = '0;
    tick;
    chk_grant(0);
    tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    check("rst2_mreq", 64'(mem_req), 64'd0);
    check("rst2_mrnw", 64'(mem_rnw), 64'd1);
    check("rst2_maddr", 64'(mem_addr), 64'd0);
    check("rst2_errs", 64'({err_overrun, err_timeout}), 64'd0);
    mem_ready = 1'b1; mem_dout = 32'h99999999;
    tick;
    mem_ready = 1'b0; mem_dout = '0;
    check("stale_done", 64'(req_done), 64'd0);
    check("stale_dout", 64'(req_dout), 64'd0);
    tick;
    check("stale_done2", 64'(req_done), 64'd0);
    check("stale_mreq", 64'(mem_req), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM channel 1 (ROM/SRAM/FLASH space) between three requesters: cart download writer, n64top core bus, savestate engine.
- Each requester uses the pulse-request / pulse-done handshake of the sdram channels.
- The arbiter latches requests, grants one at a time, and forwards a single req pulse to the controller.
- It returns ready and read data only to the granted requester, and watchdogs hung transactions.

Parameters:
- ADDR_W, 27, address width (byte address into SDRAM)
- DATA_W, 32, data width
- TIMEOUT_CYC, 1023, max cycles in WAIT before forced abort; 10-bit counter

Ports:
- clk1x  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req_ena  in  3  per-port request pulse; [0]=download, [1]=savestate, [2]=core
- req_rnw  in  3  per-port 1=read 0=write
- req_addr  in  3*ADDR_W  per-port address, packed port0 lowest
- req_be  in  3*4  per-port byte enables
- req_din  in  3*DATA_W  per-port write data
- req_done  out  3  per-port one-cycle completion pulse
- req_dout  out  DATA_W  read data, valid in the req_done cycle
- mem_req  out  1  request pulse to sdram channel
- mem_rnw  out  1  to sdram channel
- mem_addr  out  ADDR_W  to sdram channel
- mem_be  out  4  to sdram channel
- mem_din  out  DATA_W  to sdram channel
- mem_ready  in  1  completion pulse from sdram channel
- mem_dout  in  DATA_W  read data from sdram channel, valid with mem_ready
- err_overrun  out  1  sticky: request pulse while same port already pending
- err_timeout  out  1  sticky: WAIT exceeded TIMEOUT_CYC

Behaviour:
- Reset (reset_n=0 at a clk1x edge):
  - state=IDLE; pending=0; all latched cmd fields=0.
  - mem_req=0, mem_rnw=1, mem_addr/mem_be/mem_din=0.
  - req_done=0, req_dout=0, err_*=0, timeout counter=0.
- Capture: req_ena[i] at cycle T sets pending[i] and latches rnw/addr/be/din[i] at T+1.
  - If pending[i] is already 1, the new pulse is dropped, the latched command is unchanged, and err_overrun is set.
- States:
  - IDLE: if any pending, pick port p per the priority rule, clear pending[p], load mem_* from latch[p], mem_req=1 (registered, high exactly 1 cycle), go to WAIT. mem_ready in IDLE is ignored.
  - WAIT: mem_req=0; counter increments each cycle.
    - On mem_ready: req_done[p]=1 for 1 cycle next cycle, req_dout=mem_dout (writes return mem_dout as-is), go to IDLE.
    - If counter reaches TIMEOUT_CYC without mem_ready: req_done[p]=1, req_dout=0, err_timeout=1, go to IDLE.
  - Counter clears on entry to WAIT.
- Latency:
  - Earliest path: ena at T, mem_req at T+2, mem_ready at R, req_done at R+1.
  - Next grant's mem_req no earlier than R+2.
  - Back-to-back throughput is one transaction per (mem latency + 2) cycles.
- Priority (default, fixed): download > savestate > core.
- Simultaneous events:
  - req_ena[p] in the same cycle as the grant of p is accepted as a new pending, not an overrun.
  - req_ena on several ports in one cycle all latch.
  - mem_ready in the same cycle as a timeout expiry counts as success.
- Reset mid-transaction drops all pending and in-flight work. No req_done is issued. A stale mem_ready after reset is ignored in IDLE.
- Widths: no arithmetic on addresses; mem_addr passes through unmodified. Counter saturates and does not wrap.

Optional Feature:
- SDRAM_ARB_RR_EN defined: round-robin among pending ports, starting from the port after the last granted one. The last-grant pointer resets to port 2, so port 0 wins first.
- Not defined: fixed priority as above. Core may starve during download, which is acceptable because core is held in reset while cart_download is active.

Decomposition:
- Package sdram_arb_pkg: port index constants PORT_DL=0, PORT_SS=1, PORT_CORE=2, NUM_PORTS=3; state enum {IDLE, WAIT}; command struct {rnw, addr, be, din}.
- One sub-module, sdram_arb_pick: combinational pending[2:0] plus last[1:0] in, grant one-hot plus valid out. Fixed-priority or RR selection lives inside it under the macro.

Test Plan:
- Single read port2: addr=0x0100000, mem_ready 5 cycles after mem_req with 0xDEADBEEF -> mem_req at T+2 with addr 0x0100000 rnw=1; req_done[2] at R+1, req_dout=0xDEADBEEF; no other done.
- Simultaneous ena on ports 0, 1, 2 (fixed priority) -> grants in order 0, 1, 2, each mem_req only after the previous req_done; addr/din match each port's latch.
- Same with SDRAM_ARB_RR_EN, port0 re-requesting every completion -> grant order 0, 1, 2, 0, 1, 2; no port waits more than 2 transactions.
- Port 2 pulses ena twice while pending -> one transaction using the first command; err_overrun=1 and stays set until reset.
- mem_ready withheld -> after 1023 WAIT cycles req_done[p]=1, req_dout=0, err_timeout=1; next pending is granted 1 cycle later.
- reset_n low for 1 cycle during WAIT, then a late mem_ready -> no req_done, no mem_req, all outputs at reset values.
